// File: rtl/multi_cycle_control_if.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_if
// Bundles the controller <-> datapath signals of the multi-cycle MIPS core.
//   master modport : the control sequencer (reads opcode/memReady, drives
//                    every enable, select, debug state, illegal, instrCount)
//   slave modport  : the datapath / memory side (the mirror image)
// Handshake: memReady is a single-cycle "done" strobe from memory. In a
// memory state (FETCH, MEMRD, MEMWR) the controller holds its request
// (memRead or memWrite) and all state-advancing strobes until it samples
// memReady=1 on a rising clk edge; memReady is ignored everywhere else.
// ---------------------------------------------------------------------------
interface multi_cycle_control_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               memReady;
  logic               pcWrite;
  logic               pcWriteCond;
  logic               iorD;
  logic               memRead;
  logic               memWrite;
  logic               memToReg;
  logic               irWrite;
  logic               regWrite;
  logic               regDst;
  logic               aluSrcA;
  logic [1:0]         aluSrcB;
  logic [1:0]         aluOp;
  logic [1:0]         pcSource;
  logic [3:0]         state;
  logic               illegal;
  logic [COUNT_W-1:0] instrCount;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           regWrite, regDst, aluSrcA, aluSrcB, aluOp, pcSource, state,
           illegal, instrCount
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
           regWrite, regDst, aluSrcA, aluSrcB, aluOp, pcSource, state,
           illegal, instrCount
  );
endinterface

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
// Main control sequencer for the multi-cycle MIPS datapath. Moore FSM that
// walks fetch/decode/execute/memory/writeback, stalls on memReady, counts
// retired instructions and traps illegal opcodes in an absorbing state.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multi_cycle_control_if.master (opcode, memReady in; datapath
//           enables/selects, debug state, illegal, instrCount out)
// ---------------------------------------------------------------------------
module multi_cycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  multi_cycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_is_sw;
  logic [COUNT_W-1:0]   r_instr_count;
  logic                 w_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_is_sw       <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      // opcode is only valid in DECODE, so remember lw vs sw for MEMADR.
      if (r_state == S_DECODE) r_is_sw <= (bus.opcode == OP_SW);
      if (w_retire) r_instr_count <= r_instr_count + COUNT_W'(1);
    end
  end

  // Next state and retirement strobe.
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH:   if (bus.memReady) w_state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_state_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.memReady) w_state_next = S_MEMWB;
      S_MEMWR: begin
        if (bus.memReady) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_EXEC:    w_state_next = S_RWB;
      S_ADDIEX:  w_state_next = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_ILLEGAL: w_state_next = S_ILLEGAL;
      default:   w_state_next = S_ILLEGAL;   // codes 13-15
    endcase
  end

  // Moore output decode; memReady only gates the FETCH strobes.
  always_comb begin
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.memToReg    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.pcSource    = 2'b00;
    bus.illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        // rst_n term keeps write strobes quiet while reset is held.
        bus.irWrite = bus.memReady & rst_n;
        bus.pcWrite = bus.memReady & rst_n;
      end
      S_DECODE:  bus.aluSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      S_MEMWR: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
      end
      S_EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = 2'b10;
      end
      S_RWB: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 2'b01;
      end
      S_ADDIWB:  bus.regWrite = 1'b1;
      S_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = 2'b10;
      end
      S_ILLEGAL: bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.state      = r_state;
  assign bus.instrCount = r_instr_count;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Main control sequencer for the multi-cycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and steps the shared ALU, register file, PC and unified memory through fetch, decode, execute, memory and writeback. It drives `aluOp` into the existing ALU-control decoder, which turns it into `aluCode`. It stalls on a memory-ready handshake, counts retired instructions, and traps illegal opcodes.

## Interface
- `COUNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; sampled in DECODE only.
- `memReady` in 1: memory completes the current read or write this cycle.
- `pcWrite`, `pcWriteCond`, `iorD`, `memRead`, `memWrite`, `memToReg`, `irWrite`, `regWrite`, `regDst`, `aluSrcA` out 1 each: datapath enables and selects.
- `aluSrcB` out 2: 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- `aluOp` out 2: to ALU control; 00 = add, 01 = subtract, 10 = use the funct field.
- `pcSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state code, for debug.
- `illegal` out 1: sticky illegal-opcode flag.
- `instrCount` out COUNT_W: retired-instruction count.

## Operation
- Moore FSM. Outputs decode from `state`, with `memReady` gating in the memory states. Every output not listed for a state is 0.
- **FETCH (0):** `memRead`=1, `aluSrcB`=01, `aluOp`=00, `pcSource`=00. `irWrite` and `pcWrite` equal `memReady`. Goes to DECODE when `memReady`=1; otherwise stays.
- **DECODE (1):** `aluSrcB`=11, `aluOp`=00 (computes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → ILLEGAL
- **MEMADR (2):** `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. lw → MEMRD; sw → MEMWR.
- **MEMRD (3):** `memRead`=1, `iorD`=1. Goes to MEMWB when `memReady`; otherwise stays.
- **MEMWB (4):** `regWrite`=1, `memToReg`=1, `regDst`=0. → FETCH.
- **MEMWR (5):** `memWrite`=1, `iorD`=1. Goes to FETCH when `memReady`; otherwise stays.
- **EXEC (6):** `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10. → RWB.
- **RWB (7):** `regWrite`=1, `regDst`=1, `memToReg`=0. → FETCH.
- **BRANCH (8):** `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01. → FETCH.
- **ADDIEX (9):** `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. → ADDIWB.
- **ADDIWB (10):** `regWrite`=1, `regDst`=0, `memToReg`=0. → FETCH.
- **JUMP (11):** `pcWrite`=1, `pcSource`=10. → FETCH.
- **ILLEGAL (12):** `illegal`=1 and all enables 0. Absorbing; only reset exits.
- Codes 13–15 are unreachable. If entered, the FSM goes to ILLEGAL on the next edge.
- **Retirement:** `instrCount` increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, ADDIWB or JUMP.
  - It wraps modulo 2^COUNT_W.
  - It never increments on entry to ILLEGAL.

## Timing
- **Reset:** asserting `rst_n`=0 at any time, including mid-instruction or mid-stall, immediately forces `state`=FETCH, `instrCount`=0 and `illegal`=0. No clock is needed.
- **While in reset:** the FETCH decode applies. `memRead`=1, `aluSrcB`=01, and every write enable is 0 regardless of `memReady`, because reset holds `irWrite` and `pcWrite` at 0.
- **Release:** deassertion is sampled at the next rising `clk`. The first FETCH completes on the first edge with `memReady`=1.
- **Latency with `memReady` held at 1:**
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Each cycle with `memReady`=0 in FETCH, MEMRD or MEMWR adds one cycle. In those states, `irWrite`, `pcWrite` and the next-state transition are held.
- In MEMWR, `memWrite` stays 1 for every stall cycle; the memory must treat the write as idempotent.
- `memReady` is ignored in all other states.
- `opcode` matters only in DECODE; it may change freely elsewhere.

## Test plan
- **Reset then lw:** reset, then lw (opcode 100011) with `memReady`=1 → `state` sequence 0,1,2,3,4,0; `regWrite`=1 and `memToReg`=1 only in state 4; `instrCount`=1.
- **Fetch stall:** R-type with `memReady`=0 for 3 cycles in FETCH → `state` holds 0 for those 3 cycles with `irWrite`=0 and `pcWrite`=0; then 1,6,7,0; `aluOp`=10 in state 6.
- **sw stall and beq:** sw with `memReady` low 2 cycles in MEMWR → `memWrite`=1 for 3 cycles, then FETCH. Follow with beq (000100) → `state` 0,1,8,0; `aluOp`=01 and `pcWriteCond`=1 in state 8.
- **Illegal opcode:** opcode 111111 in DECODE → `state`=12 and `illegal`=1; both hold for 10 cycles; `instrCount` unchanged; `rst_n` low clears them asynchronously.
- **Reset mid-instruction:** `rst_n` low while in MEMRD → `state`=0 and `instrCount`=0 before the next edge.
- **Counter wrap:** with `COUNT_W`=4, run 17 j instructions (000010) → `instrCount` reads 1; `pcSource`=10 in each JUMP cycle.
